// File: rtl/opb_register_ppc2simulink_sync.sv
// Single-word OPB slave register driving a control word into fabric logic, with PPC readback.
// Latency: acknowledge, write data, update strobe and read data all land one cycle after the hit.
// Backpressure: none; it acks every hit once and then spends one cycle in ACK before the next.
module opb_register_ppc2simulink_sync #(
    parameter logic [31:0] C_BASEADDR    = 32'h01004200,
    parameter logic [31:0] C_HIGHADDR    = 32'h010042FF,
    parameter int          C_OPB_AWIDTH  = 32,
    parameter int          C_OPB_DWIDTH  = 32,
    parameter              C_FAMILY      = "virtex6",
    parameter logic [31:0] C_RESET_VALUE = 32'h00000000
) (
    input  logic                    OPB_Clk,
    input  logic                    OPB_Rst_n,
    input  logic [0:C_OPB_AWIDTH-1] OPB_ABus,
    input  logic [0:3]              OPB_BE,
    input  logic [0:C_OPB_DWIDTH-1] OPB_DBus,
    input  logic                    OPB_RNW,
    input  logic                    OPB_select,
    input  logic                    OPB_seqAddr,
    output logic [0:C_OPB_DWIDTH-1] Sl_DBus,
    output logic                    Sl_xferAck,
    output logic                    Sl_errAck,
    output logic                    Sl_retry,
    output logic                    Sl_toutSup,
    output logic [31:0]             user_data_out,
    output logic                    user_data_update
);

    localparam int unused_family_bits = $bits(C_FAMILY);

    typedef enum logic {IDLE, ACK} state_t;

    state_t                  state, state_nxt;
    logic [31:0]             ctrl_q, ctrl_nxt;
    logic [0:C_OPB_DWIDTH-1] rdat_nxt;
    logic                    hit, off0, take, wr_en, upd_nxt, ack_nxt;
    logic                    unused_seq;

    assign unused_seq = OPB_seqAddr;

    assign hit  = OPB_select && (OPB_ABus >= C_BASEADDR) && (OPB_ABus <= C_HIGHADDR);
    // Byte offset is ignored: any address within the first word maps to the register.
    assign off0 = ((OPB_ABus - C_BASEADDR) >> 2) == 32'd0;

    always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
        if (!OPB_Rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (hit) state_nxt = ACK;
            ACK:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        take     = (state == IDLE) && hit;
        wr_en    = take && !OPB_RNW && off0;
        upd_nxt  = wr_en && (|OPB_BE);
        ack_nxt  = take;
        rdat_nxt = (take && OPB_RNW && off0) ? ctrl_q : '0;
        ctrl_nxt = ctrl_q;
        // OPB lane 0 is the most significant byte of the user-side word.
        for (int k = 0; k < 4; k++) begin
            if (wr_en && OPB_BE[k]) begin
                ctrl_nxt[31-8*k -: 8] = OPB_DBus[8*k +: 8];
            end
        end
    end

    always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
        if (!OPB_Rst_n) begin
            ctrl_q           <= C_RESET_VALUE;
            Sl_xferAck       <= 1'b0;
            Sl_DBus          <= '0;
            user_data_update <= 1'b0;
        end else begin
            ctrl_q           <= ctrl_nxt;
            Sl_xferAck       <= ack_nxt;
            Sl_DBus          <= rdat_nxt;
            user_data_update <= upd_nxt;
        end
    end

    assign user_data_out = ctrl_q;
    assign Sl_errAck     = 1'b0;
    assign Sl_retry      = 1'b0;
    assign Sl_toutSup    = 1'b0;

endmodule

// File: tb/tb_opb_register_ppc2simulink_sync.sv
// Directed bench for opb_register_ppc2simulink_sync: bus transfers checked against a scoreboard.
module tb_opb_register_ppc2simulink_sync;

    localparam logic [31:0] BASE = 32'h01004200;
    localparam logic [31:0] HIGH = 32'h010042FF;
    localparam logic [31:0] RVAL = 32'hDEADBEEF;

    logic        clk;
    logic        rst_n;
    logic [0:31] OPB_ABus;
    logic [0:3]  OPB_BE;
    logic [0:31] OPB_DBus;
    logic        OPB_RNW;
    logic        OPB_select;
    logic        OPB_seqAddr;
    logic [0:31] Sl_DBus;
    logic        Sl_xferAck;
    logic        Sl_errAck;
    logic        Sl_retry;
    logic        Sl_toutSup;
    logic [31:0] user_data_out;
    logic        user_data_update;

    typedef struct {
        logic [31:0] rdata;
        logic        upd;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] mdl;
    int          n_chk;
    int          n_pass;

    opb_register_ppc2simulink_sync #(
        .C_BASEADDR   (BASE),
        .C_HIGHADDR   (HIGH),
        .C_RESET_VALUE(RVAL)
    ) dut (
        .OPB_Clk         (clk),
        .OPB_Rst_n       (rst_n),
        .OPB_ABus        (OPB_ABus),
        .OPB_BE          (OPB_BE),
        .OPB_DBus        (OPB_DBus),
        .OPB_RNW         (OPB_RNW),
        .OPB_select      (OPB_select),
        .OPB_seqAddr     (OPB_seqAddr),
        .Sl_DBus         (Sl_DBus),
        .Sl_xferAck      (Sl_xferAck),
        .Sl_errAck       (Sl_errAck),
        .Sl_retry        (Sl_retry),
        .Sl_toutSup      (Sl_toutSup),
        .user_data_out   (user_data_out),
        .user_data_update(user_data_update)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // One single-beat transfer, issued at a negedge; select is dropped after one cycle.
    task automatic xfer(input logic [31:0] addr, input logic rnw, input logic [0:3] be,
                        input logic [31:0] wdata, input string tag);
        logic hit, off0, seen;
        exp_t e;
        int   lat, acks, nz;
        hit  = (addr >= BASE) && (addr <= HIGH);
        off0 = hit && (((addr - BASE) >> 2) == 32'd0);
        e.rdata = (rnw && off0) ? mdl : 32'h0;
        e.upd   = !rnw && off0 && (be != 4'b0000);
        if (!rnw && off0) begin
            for (int k = 0; k < 4; k++) begin
                if (be[k]) mdl[31-8*k -: 8] = wdata[31-8*k -: 8];
            end
        end
        if (hit) sb.push_back(e);
        OPB_ABus   = addr;
        OPB_RNW    = rnw;
        OPB_BE     = be;
        OPB_DBus   = wdata;
        OPB_select = 1'b1;
        if (hit) begin
            seen = 1'b0;
            lat  = 0;
            for (int c = 1; c <= 5 && !seen; c++) begin
                @(negedge clk);
                if (c == 1) OPB_select = 1'b0;
                if (Sl_xferAck) begin
                    seen = 1'b1;
                    lat  = c;
                end
            end
            chk({tag, " ack latency"}, lat, 1);
            if (seen) begin
                e = sb.pop_front();
                chk({tag, " rdata"}, Sl_DBus, e.rdata);
                chk({tag, " update"}, {31'b0, user_data_update}, {31'b0, e.upd});
            end else begin
                sb.delete();
            end
            @(negedge clk);
            chk({tag, " idle after ack"}, {Sl_xferAck, user_data_update, Sl_DBus[2:31]},
                32'h0);
        end else begin
            acks = 0;
            nz   = 0;
            for (int c = 1; c <= 20; c++) begin
                @(negedge clk);
                if (c == 1) OPB_select = 1'b0;
                if (Sl_xferAck) acks++;
                if (Sl_DBus != 32'h0) nz++;
            end
            chk({tag, " no ack"}, acks, 0);
            chk({tag, " dbus zero"}, nz, 0);
        end
        chk({tag, " user_data_out"}, user_data_out, mdl);
    endtask

    logic [31:0] wr[4];
    int          lat, stray, acks;
    logic        seen;
    exp_t        e;

    initial begin
        n_chk       = 0;
        n_pass      = 0;
        rst_n       = 1'b0;
        OPB_ABus    = '0;
        OPB_BE      = '0;
        OPB_DBus    = '0;
        OPB_RNW     = 1'b0;
        OPB_select  = 1'b0;
        OPB_seqAddr = 1'b0;
        mdl         = RVAL;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        chk("reset user_data_out", user_data_out, RVAL);
        chk("reset ack/update", {30'b0, Sl_xferAck, user_data_update}, 32'h0);
        chk("reset Sl_DBus", Sl_DBus, 32'h0);
        chk("tie-offs", {29'b0, Sl_errAck, Sl_retry, Sl_toutSup}, 32'h0);
        @(negedge clk);

        xfer(32'h01004200, 1'b1, 4'b1111, 32'h0, "read reset value");
        xfer(32'h01004200, 1'b0, 4'b1111, 32'h12345678, "full write");
        xfer(32'h01004200, 1'b1, 4'b0000, 32'h0, "readback full");
        xfer(32'h01004200, 1'b0, 4'b0101, 32'hAABBCCDD, "partial write");
        chk("partial value", user_data_out, 32'h12BB56DD);
        xfer(32'h01004203, 1'b1, 4'b1111, 32'h0, "byte offset read");
        xfer(32'h01004200, 1'b0, 4'b0000, 32'hFFFFFFFF, "no-BE write");
        xfer(32'h01004204, 1'b0, 4'b1111, 32'hFFFFFFFF, "offset4 write");
        xfer(32'h01004204, 1'b1, 4'b1111, 32'h0, "offset4 read");
        xfer(32'h010042FF, 1'b1, 4'b1111, 32'h0, "high edge read");
        xfer(32'h01004300, 1'b1, 4'b1111, 32'h0, "above range");
        xfer(32'h010041FC, 1'b0, 4'b1111, 32'h0BADF00D, "below range");

        // Select glitch that never reaches a sampling edge.
        OPB_ABus = BASE;
        OPB_RNW  = 1'b0;
        OPB_BE   = 4'b1111;
        OPB_DBus = 32'h55555555;
        OPB_select = 1'b1;
        #2 OPB_select = 1'b0;
        acks = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (Sl_xferAck || user_data_update) acks++;
        end
        chk("select glitch no ack", acks, 0);
        chk("select glitch value", user_data_out, mdl);

        // Back-to-back writes with select held high.
        wr[0] = 32'h11111111;
        wr[1] = 32'h22222222;
        wr[2] = 32'h33333333;
        wr[3] = 32'h44444444;
        stray = 0;
        OPB_ABus   = BASE;
        OPB_RNW    = 1'b0;
        OPB_BE     = 4'b1111;
        OPB_DBus   = wr[0];
        OPB_select = 1'b1;
        for (int i = 0; i < 4; i++) begin
            sb.push_back('{rdata: 32'h0, upd: 1'b1});
            mdl  = wr[i];
            seen = 1'b0;
            lat  = 0;
            for (int c = 1; c <= 6 && !seen; c++) begin
                @(negedge clk);
                if (user_data_update && !Sl_xferAck) stray++;
                if (Sl_xferAck) begin
                    seen = 1'b1;
                    lat  = c;
                end
            end
            chk($sformatf("b2b%0d ack spacing", i), lat, (i == 0) ? 1 : 2);
            if (seen) begin
                e = sb.pop_front();
                chk($sformatf("b2b%0d update", i), {31'b0, user_data_update}, {31'b0, e.upd});
                chk($sformatf("b2b%0d value", i), user_data_out, wr[i]);
            end else begin
                sb.delete();
            end
            if (i < 3) OPB_DBus = wr[i+1];
            else OPB_select = 1'b0;
        end
        @(negedge clk);
        if (user_data_update || Sl_xferAck) stray++;
        chk("b2b stray strobes/acks", stray, 0);
        chk("b2b final value", user_data_out, 32'h44444444);

        // Reset asserted during the ACK cycle.
        OPB_ABus   = BASE;
        OPB_RNW    = 1'b0;
        OPB_BE     = 4'b1111;
        OPB_DBus   = 32'hCAFEF00D;
        OPB_select = 1'b1;
        sb.push_back('{rdata: 32'h0, upd: 1'b1});
        @(negedge clk);
        OPB_select = 1'b0;
        chk("midreset ack before", {31'b0, Sl_xferAck}, 32'h1);
        e = sb.pop_front();
        chk("midreset update before", {31'b0, user_data_update}, {31'b0, e.upd});
        chk("midreset value before", user_data_out, 32'hCAFEF00D);
        #2 rst_n = 1'b0;
        #1;
        mdl = RVAL;
        chk("midreset ack dropped", {31'b0, Sl_xferAck}, 32'h0);
        chk("midreset update dropped", {31'b0, user_data_update}, 32'h0);
        chk("midreset value", user_data_out, RVAL);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        xfer(32'h01004200, 1'b1, 4'b1111, 32'h0, "read after midreset");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
